// File: rtl/riscv_fetch.sv
// riscv_fetch: instruction-fetch stage for the riscv32i core.
//
// A PC generator issues word-aligned requests on a request/grant memory port
// (responses in order, at least one cycle after grant). Responses land in a
// prefetch FIFO whose head is offered to decode over valid/ready. Requests are
// credit-limited so buffered plus in-flight words never exceed FIFO_DEPTH.
// A redirect flushes the FIFO and marks every in-flight response for discard.
//
// Parameters:
//   N_param    - address/data width
//   FIFO_DEPTH - prefetch entries / fetch credit (power of 2, >= 2)
//   RESET_PC   - first fetch address
//
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   imem_req_o/addr_o     - fetch request and word-aligned address
//   imem_gnt_i            - memory accepts the request this cycle
//   imem_rvalid_i/rdata_i - in-order response
//   instr_valid_o/instr_o/instr_pc_o, instr_ready_i - decode handshake
//   redirect_i/redirect_pc_i - flush and refetch from new PC
//   perf_fetched_o/perf_flushed_o - delivered / discarded counters
//
// Configuration macro: RISCV_FETCH_PERF_EN enables the perf counters; when
// undefined both perf ports are tied to 0.

module riscv_fetch #(
    parameter int unsigned        N_param    = 32,
    parameter int unsigned        FIFO_DEPTH = 4,
    parameter logic [N_param-1:0] RESET_PC   = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_o,
    output logic [N_param-1:0] imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [N_param-1:0] imem_rdata_i,
    output logic               instr_valid_o,
    output logic [N_param-1:0] instr_o,
    output logic [N_param-1:0] instr_pc_o,
    input  logic               instr_ready_i,
    input  logic               redirect_i,
    input  logic [N_param-1:0] redirect_pc_i,
    output logic [31:0]        perf_fetched_o,
    output logic [31:0]        perf_flushed_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef struct packed {
        logic [N_param-1:0] pc;
        logic [N_param-1:0] instr;
    } fetch_entry_t;

    // State
    logic               run_q,      run_d;
    logic               req_q,      req_d;
    logic               valid_q,    valid_d;
    fetch_entry_t       head_q,     head_d;
    logic [N_param-1:0] fetch_pc_q, fetch_pc_d;
    logic [N_param-1:0] resp_pc_q,  resp_pc_d;
    logic [CNT_W-1:0]   out_cnt_q,  out_cnt_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]   count_q,    count_d;
    logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
    fetch_entry_t       fifo_q [FIFO_DEPTH];
    fetch_entry_t       fifo_d [FIFO_DEPTH];

    // Per-cycle events
    logic               grant;
    logic               drop_now;
    logic               keep;
    logic               pop;
    logic [N_param-1:0] redirect_pc_aligned;

    // Low address bits of the redirect target are architecturally ignored
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    assign grant               = req_q && imem_gnt_i;
    assign drop_now            = imem_rvalid_i && (drop_cnt_q != '0);
    assign keep                = imem_rvalid_i && (drop_cnt_q == '0) && !redirect_i;
    assign pop                 = valid_q && instr_ready_i;
    assign redirect_pc_aligned = {redirect_pc_i[N_param-1:2], 2'b00};

    // Next-state logic; redirect overrides everything but out_cnt accounting
    always_comb begin
        run_d      = 1'b1;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        out_cnt_d  = out_cnt_q;
        drop_cnt_d = drop_cnt_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_d     = fifo_q;

        if (grant && !imem_rvalid_i) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end else if (!grant && imem_rvalid_i) begin
            out_cnt_d = out_cnt_q - CNT_W'(1);
        end

        if (keep) begin
            fifo_d[wr_ptr_q] = '{pc: resp_pc_q, instr: imem_rdata_i};
        end

        if (redirect_i) begin
            fetch_pc_d = redirect_pc_aligned;
            resp_pc_d  = redirect_pc_aligned;
            // Everything still outstanding after this edge is stale
            drop_cnt_d = out_cnt_d;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + N_param'(4);
            end
            if (drop_now) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
            if (keep) begin
                resp_pc_d = resp_pc_q + N_param'(4);
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (keep && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!keep && pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end

        // Outputs registered from next-state values
        req_d   = run_d && ((SUM_W'(count_d) + SUM_W'(out_cnt_d)) < SUM_W'(FIFO_DEPTH));
        valid_d = (count_d != '0);
        head_d  = fifo_d[rd_ptr_d];
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q      <= 1'b0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            head_q     <= '0;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            run_q      <= run_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_q     <= fifo_d;
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = fetch_pc_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = head_q.instr;
    assign instr_pc_o    = head_q.pc;

`ifdef RISCV_FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_flushed_q, perf_flushed_d;

    // Flushed = discarded responses plus FIFO entries lost to a redirect
    // (a head popped in the redirect cycle counts as delivered instead)
    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(pop);
        perf_flushed_d = perf_flushed_q;
        if (redirect_i) begin
            perf_flushed_d = perf_flushed_q + 32'(imem_rvalid_i) + 32'(count_q) - 32'(pop);
        end else if (drop_now) begin
            perf_flushed_d = perf_flushed_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end

    assign perf_fetched_o = perf_fetched_q;
    assign perf_flushed_o = perf_flushed_q;
`else
    assign perf_fetched_o = 32'd0;
    assign perf_flushed_o = 32'd0;
`endif

endmodule

// File: tb/tb_riscv_fetch.sv
// Bench for riscv_fetch: a transaction-level model (memory request queue tagged
// with a redirect epoch, plus a queue of words owed to decode) predicts every
// output each cycle; directed scenarios add hand-computed literal checks.

module tb_riscv_fetch;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] perf_fetched_o;
    logic [31:0] perf_flushed_o;

    riscv_fetch #(
        .N_param   (32),
        .FIFO_DEPTH(DEPTH),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .perf_fetched_o(perf_fetched_o),
        .perf_flushed_o(perf_flushed_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard counters
    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    mreq_t       mq[$];        // granted, not yet answered by memory
    logic [31:0] fq[$];        // PCs of words owed to decode, in order
    int          cyc;
    int          epoch;
    int          lat;
    int          m_grants;
    bit          m_run;
    logic [31:0] exp_fetch;
    logic [31:0] m_fetched;
    logic [31:0] m_flushed;
    logic        s_req;
    logic        s_valid;
    logic [31:0] s_addr;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h3C5A_0F96;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        fq.delete();
        cyc       = 0;
        epoch     = 0;
        m_grants  = 0;
        m_run     = 1'b0;
        exp_fetch = 32'h0000_0000;
        m_fetched = '0;
        m_flushed = '0;
    endtask

    // Compare every DUT output against the model's prediction
    task automatic check_outputs();
        chk("instr_valid", 32'(instr_valid_o), 32'(fq.size() != 0));
        if (fq.size() != 0) begin
            chk("instr_pc", instr_pc_o, fq[0]);
            chk("instr", instr_o, word_of(fq[0]));
        end
        chk("imem_req", 32'(imem_req_o), 32'(m_run && (fq.size() + mq.size() < DEPTH)));
        chk("imem_addr", imem_addr_o, exp_fetch);
`ifdef RISCV_FETCH_PERF_EN
        chk("perf_fetched", perf_fetched_o, m_fetched);
        chk("perf_flushed", perf_flushed_o, m_flushed);
`else
        chk("perf_fetched", perf_fetched_o, 32'd0);
        chk("perf_flushed", perf_flushed_o, 32'd0);
`endif
    endtask

    // Apply the transaction of the cycle that just ended
    task automatic update_model();
        mreq_t e;
        bit    grant;
        bit    pop;
        grant = s_req && imem_gnt_i;
        pop   = s_valid && instr_ready_i;
        if (pop) begin
            m_fetched++;
            if (fq.size() != 0) fq.delete(0);
        end
        if (redirect_i) begin
            m_flushed += 32'(fq.size());
            fq.delete();
        end
        if (imem_rvalid_i && mq.size() != 0) begin
            e = mq.pop_front();
            if (redirect_i || e.epoch != epoch) m_flushed++;
            else fq.push_back(e.addr);
        end
        if (grant) begin
            m_grants++;
            mq.push_back('{addr: s_addr, epoch: epoch, due: cyc + lat});
        end
        if (redirect_i) begin
            epoch++;
            exp_fetch = redirect_pc_i & 32'hFFFF_FFFC;
        end else if (grant) begin
            exp_fetch = exp_fetch + 32'd4;
        end
        m_run = 1'b1;
        cyc++;
    endtask

    task automatic drive_mem();
        if (reset && mq.size() != 0 && mq[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = word_of(mq[0].addr);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        s_req   = imem_req_o;
        s_valid = instr_valid_o;
        s_addr  = imem_addr_o;
        @(posedge clk);
        #1;
        if (reset) update_model();
        else       model_clear();
        drive_mem();
    endtask

    // Asynchronous reset asserted and released between clock edges
    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_instr_pc", instr_pc_o, 32'd0);
        chk("rst_addr", imem_addr_o, 32'h0000_0000);
        chk("rst_perf_fetched", perf_fetched_o, 32'd0);
        chk("rst_perf_flushed", perf_flushed_o, 32'd0);
        model_clear();
        redirect_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        repeat (2) cycle();
        #2;
        reset = 1'b1;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        while (!instr_valid_o && n < budget) begin
            cycle();
            n++;
        end
        if (!instr_valid_o) chk(name, 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        logic [31:0] held_addr;
        reset         = 1'b1;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        lat           = 1;
        model_clear();

        // Streaming from reset: 1-cycle memory, ready high
        imem_gnt_i    = 1'b1;
        instr_ready_i = 1'b1;
        do_reset();
        cycle();
        chk("t1_req_cycle1", 32'(imem_req_o), 32'd1);
        chk("t1_addr_cycle1", imem_addr_o, 32'h0);
        cycle();
        chk("t1_addr_cycle2", imem_addr_o, 32'h4);
        chk("t1_valid_cycle2", 32'(instr_valid_o), 32'd0);
        cycle();
        chk("t1_valid_cycle3", 32'(instr_valid_o), 32'd1);
        chk("t1_pc_cycle3", instr_pc_o, 32'h0);
        chk("t1_instr_cycle3", instr_o, word_of(32'h0));
        cycle();
        chk("t1_pc_cycle4", instr_pc_o, 32'h4);
        repeat (10) cycle();

        // Back-pressure: ready low from reset
        instr_ready_i = 1'b0;
        do_reset();
        repeat (12) cycle();
        chk("t2_grants", 32'(m_grants), 32'd4);
        chk("t2_req_low", 32'(imem_req_o), 32'd0);
        chk("t2_head_pc", instr_pc_o, 32'h0);
        instr_ready_i = 1'b1;
        cycle();
        chk("t2_req_resume", 32'(imem_req_o), 32'd1);
        repeat (12) cycle();

        // Redirect with 2 in flight and 2 buffered
        instr_ready_i = 1'b0;
        lat = 2;
        do_reset();
        n = 0;
        while (!(fq.size() == 2 && mq.size() == 2) && n < 20) begin
            cycle();
            n++;
        end
        chk("t3_setup_reached", 32'(fq.size() == 2 && mq.size() == 2), 32'd1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        cycle();
        redirect_i    = 1'b0;
        instr_ready_i = 1'b1;
        wait_valid("t3_timeout", 20);
        chk("t3_next_pc", instr_pc_o, 32'h100);
`ifdef RISCV_FETCH_PERF_EN
        chk("t3_perf_flushed", perf_flushed_o, 32'd4);
`else
        chk("t3_perf_flushed", perf_flushed_o, 32'd0);
`endif
        repeat (8) cycle();

        // Redirect coinciding with a grant and a response
        lat = 1;
        do_reset();
        repeat (6) cycle();
        n = 0;
        while (!(imem_req_o && imem_rvalid_i) && n < 10) begin
            cycle();
            n++;
        end
        chk("t4_setup_reached", 32'(imem_req_o && imem_rvalid_i), 32'd1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        cycle();
        redirect_i = 1'b0;
        wait_valid("t4_timeout", 10);
        chk("t4_next_pc", instr_pc_o, 32'h200);
        chk("t4_next_instr", instr_o, word_of(32'h200));
`ifdef RISCV_FETCH_PERF_EN
        chk("t4_perf_flushed", perf_flushed_o, 32'd2);
`else
        chk("t4_perf_flushed", perf_flushed_o, 32'd0);
`endif

        // Grant stalled for 5 cycles: request and address hold
        imem_gnt_i = 1'b0;
        cycle();
        held_addr = imem_addr_o;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t5_req_hold", 32'(imem_req_o), 32'd1);
            chk("t5_addr_hold", imem_addr_o, held_addr);
        end
        imem_gnt_i = 1'b1;
        repeat (10) cycle();

        // Mid-stream asynchronous reset, then restart
        do_reset();
        cycle();
        chk("t6_req_restart", 32'(imem_req_o), 32'd1);
        chk("t6_addr_restart", imem_addr_o, 32'h0);
        chk("t6_perf_fetched", perf_fetched_o, 32'd0);
        repeat (6) cycle();

        // Mixed traffic with stalls, back-pressure, latency and redirects
        do_reset();
        for (int i = 0; i < 300; i++) begin
            imem_gnt_i    = ($urandom_range(0, 3) != 0);
            instr_ready_i = ($urandom_range(0, 2) != 0);
            lat           = $urandom_range(1, 3);
            redirect_i    = ($urandom_range(0, 15) == 0);
            redirect_pc_i = $urandom();
            cycle();
        end
        redirect_i = 1'b0;
        repeat (4) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
